// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM that sequences the shared-memory
// datapath through fetch, decode and the per-class execute/writeback states.
// The opcode is captured once in DECODE so later states ignore the live bus.
module mips_multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic [1:0] alu_op,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic       zero_ext,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam logic [3:0] FETCH  = 4'd0;
   localparam logic [3:0] DECODE = 4'd1;
   localparam logic [3:0] MEMADR = 4'd2;
   localparam logic [3:0] MEMRD  = 4'd3;
   localparam logic [3:0] MEMWB  = 4'd4;
   localparam logic [3:0] MEMWR  = 4'd5;
   localparam logic [3:0] REXEC  = 4'd6;
   localparam logic [3:0] RWB    = 4'd7;
   localparam logic [3:0] BRANCH = 4'd8;
   localparam logic [3:0] JUMP   = 4'd9;
   localparam logic [3:0] IEXEC  = 4'd10;
   localparam logic [3:0] IWB    = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   logic [3:0] state_reg;
   logic [3:0] state_next;
   logic [5:0] opcode_reg;
   logic       op_legal;

   assign state = state_reg;

   // Opcode recognised by the decoder (drives both dispatch and illegal_op).
   always_comb begin
      unique case (opcode)
         OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LW, OP_SW: op_legal = 1'b1;
         default:                                               op_legal = 1'b0;
      endcase
   end

   // State and latched opcode; reset returns to FETCH immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= FETCH;
         opcode_reg <= 6'h00;
      end else begin
         state_reg <= state_next;
         if (state_reg == DECODE)
            opcode_reg <= opcode;
      end
   end

   // Next-state selection; unused codes fall back to FETCH.
   always_comb begin
      state_next = FETCH;
      case (state_reg)
         FETCH:  state_next = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_RTYPE:      state_next = REXEC;
               OP_LW, OP_SW:  state_next = MEMADR;
               OP_BEQ:        state_next = BRANCH;
               OP_J:          state_next = JUMP;
               OP_ADDI,
               OP_ORI:        state_next = IEXEC;
               default:       state_next = FETCH;
            endcase
         end
         MEMADR: state_next = (opcode_reg == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  state_next = mem_ready ? MEMWB : MEMRD;
         MEMWB:  state_next = FETCH;
         MEMWR:  state_next = mem_ready ? FETCH : MEMWR;
         REXEC:  state_next = RWB;
         RWB:    state_next = FETCH;
         BRANCH: state_next = FETCH;
         JUMP:   state_next = FETCH;
         IEXEC:  state_next = IWB;
         IWB:    state_next = FETCH;
         default: state_next = FETCH;
      endcase
   end

   // Output decode from the registered state; reset forces every control to 0.
   // Only FETCH's write strobes look at mem_ready so a stalled fetch writes nothing.
   always_comb begin
      alu_op        = 2'b00;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      zero_ext      = 1'b0;
      illegal_op    = 1'b0;
      if (!reset) begin
         case (state_reg)
            FETCH: begin
               mem_read  = 1'b1;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
               alu_src_b = 2'b01;
            end
            DECODE: begin
               alu_src_b  = 2'b11;
               illegal_op = ~op_legal;
            end
            MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            MEMRD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MEMWR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            REXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            RWB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
            end
            JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
            IEXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               if (opcode_reg == OP_ORI) begin
                  alu_op   = 2'b11;
                  zero_ext = 1'b1;
               end
            end
            IWB: begin
               reg_write = 1'b1;
               zero_ext  = (opcode_reg == OP_ORI);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle control FSM. Each step drives inputs just
// after a rising edge and queues the expected control word; a negedge checker
// pops and compares it against the DUT outputs.
module tb_mips_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic [1:0] alu_op;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, pc_source;
   logic       zero_ext, illegal_op;
   logic [3:0] state;

   typedef struct {
      string       tag;
      logic [21:0] word;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mips_multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .alu_op(alu_op), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .pc_source(pc_source), .zero_ext(zero_ext), .illegal_op(illegal_op),
      .state(state)
   );

   // Word layout: state, alu_op, pc_write, pc_write_cond, i_or_d, mem_read,
   // mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
   // alu_src_b, pc_source, zero_ext, illegal_op
   localparam logic [21:0] E_RST   = {4'd0, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00, 1'b0,1'b0};
   localparam logic [21:0] E_FSTL  = {4'd0, 2'b00, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01, 2'b00, 1'b0,1'b0};
   localparam logic [21:0] E_FETCH = {4'd0, 2'b00, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01, 2'b00, 1'b0,1'b0};
   localparam logic [21:0] E_DEC   = {4'd1, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11, 2'b00, 1'b0,1'b0};
   localparam logic [21:0] E_ILL   = {4'd1, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11, 2'b00, 1'b0,1'b1};
   localparam logic [21:0] E_MADR  = {4'd2, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 2'b00, 1'b0,1'b0};
   localparam logic [21:0] E_MRD   = {4'd3, 2'b00, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00, 1'b0,1'b0};
   localparam logic [21:0] E_MWB   = {4'd4, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 2'b00, 2'b00, 1'b0,1'b0};
   localparam logic [21:0] E_MWR   = {4'd5, 2'b00, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00, 1'b0,1'b0};
   localparam logic [21:0] E_REX   = {4'd6, 2'b10, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 2'b00, 1'b0,1'b0};
   localparam logic [21:0] E_RWB   = {4'd7, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b00, 2'b00, 1'b0,1'b0};
   localparam logic [21:0] E_BR    = {4'd8, 2'b01, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 2'b01, 1'b0,1'b0};
   localparam logic [21:0] E_JMP   = {4'd9, 2'b00, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b10, 1'b0,1'b0};
   localparam logic [21:0] E_IEXO  = {4'd10,2'b11, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 2'b00, 1'b1,1'b0};
   localparam logic [21:0] E_IEXA  = {4'd10,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 2'b00, 1'b0,1'b0};
   localparam logic [21:0] E_IWBO  = {4'd11,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00, 2'b00, 1'b1,1'b0};
   localparam logic [21:0] E_IWBA  = {4'd11,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00, 2'b00, 1'b0,1'b0};

   logic [21:0] obs;
   assign obs = {state, alu_op, pc_write, pc_write_cond, i_or_d, mem_read,
                 mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                 alu_src_b, pc_source, zero_ext, illegal_op};

   // Scoreboard checker: one queued expectation per cycle, compared mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         assert (obs === e.word) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.word);
         end
         $display("step %-10s state=%0d word=%h", e.tag, state, obs);
      end
      n_checks++;
      assert ((pc_write & pc_write_cond) !== 1'b1) else begin
         n_fail++;
         $error("FAIL pc_excl: observed pc_write=%b pc_write_cond=%b expected not both 1",
                pc_write, pc_write_cond);
      end
   end

   task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                       input logic [21:0] w, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      reset     = r;
      opcode    = op;
      mem_ready = rdy;
      e.tag  = tag;
      e.word = w;
      exp_q.push_back(e);
   endtask

   initial begin
      reset     = 1'b1;
      opcode    = 6'h00;
      mem_ready = 1'b0;

      // reset holds FETCH with everything low
      step(1'b1, 6'h00, 1'b1, E_RST,   "rst0");
      step(1'b1, 6'h00, 1'b1, E_RST,   "rst1");
      step(1'b0, 6'h3F, 1'b0, E_FSTL,  "f_stall");
      // R-type
      step(1'b0, 6'h3F, 1'b1, E_FETCH, "r_fetch");
      step(1'b0, 6'h00, 1'b1, E_DEC,   "r_dec");
      step(1'b0, 6'h3F, 1'b1, E_REX,   "r_exec");
      step(1'b0, 6'h3F, 1'b1, E_RWB,   "r_wb");
      // lw with two stall cycles; opcode bus changes after DECODE
      step(1'b0, 6'h3F, 1'b1, E_FETCH, "lw_fetch");
      step(1'b0, 6'h23, 1'b1, E_DEC,   "lw_dec");
      step(1'b0, 6'h2B, 1'b1, E_MADR,  "lw_adr");
      step(1'b0, 6'h2B, 1'b0, E_MRD,   "lw_rd_s0");
      step(1'b0, 6'h2B, 1'b0, E_MRD,   "lw_rd_s1");
      step(1'b0, 6'h2B, 1'b1, E_MRD,   "lw_rd");
      step(1'b0, 6'h2B, 1'b1, E_MWB,   "lw_wb");
      // ori with opcode bus cleared after DECODE
      step(1'b0, 6'h3F, 1'b1, E_FETCH, "ori_fetch");
      step(1'b0, 6'h0D, 1'b1, E_DEC,   "ori_dec");
      step(1'b0, 6'h00, 1'b1, E_IEXO,  "ori_exec");
      step(1'b0, 6'h00, 1'b1, E_IWBO,  "ori_wb");
      // addi
      step(1'b0, 6'h3F, 1'b1, E_FETCH, "addi_fetch");
      step(1'b0, 6'h08, 1'b1, E_DEC,   "addi_dec");
      step(1'b0, 6'h0D, 1'b1, E_IEXA,  "addi_exec");
      step(1'b0, 6'h0D, 1'b1, E_IWBA,  "addi_wb");
      // beq then j
      step(1'b0, 6'h3F, 1'b1, E_FETCH, "beq_fetch");
      step(1'b0, 6'h04, 1'b1, E_DEC,   "beq_dec");
      step(1'b0, 6'h3F, 1'b1, E_BR,    "beq_br");
      step(1'b0, 6'h3F, 1'b1, E_FETCH, "j_fetch");
      step(1'b0, 6'h02, 1'b1, E_DEC,   "j_dec");
      step(1'b0, 6'h3F, 1'b1, E_JMP,   "j_jump");
      // sw without stall
      step(1'b0, 6'h3F, 1'b1, E_FETCH, "sw_fetch");
      step(1'b0, 6'h2B, 1'b1, E_DEC,   "sw_dec");
      step(1'b0, 6'h23, 1'b1, E_MADR,  "sw_adr");
      step(1'b0, 6'h23, 1'b1, E_MWR,   "sw_wr");
      // illegal opcode: one-cycle pulse then back to FETCH
      step(1'b0, 6'h3F, 1'b1, E_FETCH, "ill_fetch");
      step(1'b0, 6'h3F, 1'b1, E_ILL,   "ill_dec");
      step(1'b0, 6'h3F, 1'b1, E_FETCH, "ill_after");
      // sw stalled, reset mid-write, then FETCH waits on mem_ready
      step(1'b0, 6'h2B, 1'b1, E_DEC,   "swr_dec");
      step(1'b0, 6'h3F, 1'b1, E_MADR,  "swr_adr");
      step(1'b0, 6'h3F, 1'b0, E_MWR,   "swr_wr_s0");
      step(1'b0, 6'h3F, 1'b0, E_MWR,   "swr_wr_s1");
      step(1'b1, 6'h3F, 1'b0, E_RST,   "swr_rst");
      step(1'b1, 6'h3F, 1'b1, E_RST,   "swr_rst2");
      step(1'b0, 6'h3F, 1'b0, E_FSTL,  "swr_fst0");
      step(1'b0, 6'h3F, 1'b0, E_FSTL,  "swr_fst1");
      step(1'b0, 6'h3F, 1'b1, E_FETCH, "swr_fetch");
      step(1'b0, 6'h00, 1'b1, E_DEC,   "post_dec");
      step(1'b0, 6'h00, 1'b1, E_REX,   "post_exec");

      @(negedge clk);
      #1;
      n_checks++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL drain: observed %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and reset.
REQ-002 Port list SHALL be (clock and reset first):
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- opcode  input  6  instr[31:26]; sampled only in DECODE
- mem_ready  input  1  memory access complete this cycle
- alu_op  output  2  to ALU control decoder: 00 add, 01 sub, 10 R-format, 11 ori
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write  output  1 each  datapath strobes
- mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath selects and strobes
- alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- pc_source  output  2  00 ALU result, 01 ALU out register, 10 jump target
- zero_ext  output  1  immediate is zero-extended (ori)
- illegal_op  output  1  one-cycle pulse on unsupported opcode
- state  output  4  current state, for debug
REQ-003 Parameters: none; the state and opcode encodings below are fixed.

Function
REQ-004 Moore FSM; all outputs except illegal_op SHALL decode from the registered state only.
REQ-005 States SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11; codes 12-15 SHALL go to FETCH on the next edge with all strobes 0.
REQ-006 FETCH: mem_read=1, ir_write=1, alu_src_b=01, alu_op=00, pc_write=1, pc_source=00, all gated by mem_ready. Hold while mem_ready=0 with all write strobes (ir_write, pc_write) 0. Go to DECODE when mem_ready=1.
REQ-007 DECODE: alu_src_b=11, alu_op=00. Next state by opcode:
- 0x00: REXEC
- 0x23 or 0x2B: MEMADR
- 0x04: BRANCH
- 0x02: JUMP
- 0x08 or 0x0D: IEXEC
- any other: FETCH, with illegal_op=1 for exactly this cycle.
REQ-008 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEMRD for lw (0x23), MEMWR for sw (0x2B), using the opcode latched in DECODE.
REQ-009 MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then MEMWB.
REQ-010 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
REQ-011 MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready=1, then FETCH. mem_write SHALL stay asserted through the stall.
REQ-012 REXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Then RWB.
REQ-013 RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
REQ-014 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Then FETCH.
REQ-015 JUMP: pc_write=1, pc_source=10. Then FETCH.
REQ-016 IEXEC: alu_src_a=1, alu_src_b=10. For latched opcode 0x0D: alu_op=11, zero_ext=1. For 0x08: alu_op=00, zero_ext=0. Then IWB.
REQ-017 IWB: reg_write=1, reg_dst=0, mem_to_reg=0, zero_ext held as in IEXEC. Then FETCH.
REQ-018 The opcode SHALL be latched into a 6-bit register on the DECODE cycle. States after DECODE SHALL use only the latched value.
REQ-019 Unlisted outputs SHALL be 0 in every state. pc_write and pc_write_cond SHALL never both be 1.
REQ-020 Cycle counts SHALL be (mem_ready held 1): lw 5, sw 4, R-type 4, ori/addi 4, beq 3, j 3.

Reset
REQ-021 While reset=1: state=FETCH, latched opcode=0, illegal_op=0, all strobes forced 0 (including FETCH's mem_read and ir_write), alu_op=00, regardless of clk.
REQ-022 Reset asserted mid-instruction SHALL abort it immediately with no further write strobes. After deassertion, the first rising edge is evaluated from FETCH.

Verification
REQ-023 R-type: opcode 0x00, mem_ready=1 -> states 0,1,6,7,0; alu_op=10 in REXEC; reg_write=1 and reg_dst=1 only in RWB.
REQ-024 lw with stall: opcode 0x23, mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; mem_read=1 throughout MEMRD; reg_write=1 and mem_to_reg=1 in MEMWB.
REQ-025 ori: opcode 0x0D, with opcode changed to 0x00 after DECODE -> states 0,1,10,11,0; alu_op=11 and zero_ext=1 in IEXEC.
REQ-026 beq then j: opcode 0x04 -> BRANCH with alu_op=01, pc_write_cond=1, pc_source=01. Then opcode 0x02 -> JUMP with pc_write=1, pc_source=10.
REQ-027 Illegal opcode 0x3F -> illegal_op=1 for exactly one cycle in DECODE, next state FETCH, no write strobe asserted.
REQ-028 Reset asserted during MEMWR with mem_ready=0 -> mem_write drops to 0 before the next clk edge, state=0. After release, FETCH waits on mem_ready.
